// File: rtl/transmissor_senha.sv
// Serial code transmitter for an electronic lock: shifts a parallel code out MSB first,
// waits for the lock's LED response, and enforces a lockout after repeated failures.
module transmissor_senha #(
    parameter int unsigned CODE_W      = 6,
    parameter int unsigned RESP_WAIT   = 4,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CODE_W-1:0] code,
    input  logic              led_verde,
    input  logic              led_vermelho,
    output logic              x,
    output logic              busy,
    output logic              done,
    output logic              ok,
    output logic              fail,
    output logic              lockout
);

    localparam int unsigned BitW  = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int unsigned WaitW = (RESP_WAIT > 1) ? $clog2(RESP_WAIT) : 1;
    localparam int unsigned LockW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int unsigned FailW = $clog2(MAX_FAIL + 1);

    localparam logic [BitW-1:0]  BitLast  = BitW'(CODE_W - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(RESP_WAIT - 1);
    localparam logic [LockW-1:0] LockLast = LockW'(LOCK_CYCLES - 1);
    localparam logic [FailW-1:0] FailMax  = FailW'(MAX_FAIL);
    localparam logic [FailW-1:0] FailPrev = FailW'(MAX_FAIL - 1);

    typedef enum logic [1:0] {StIdle, StSend, StWaitResp, StLockout} state_e;

    state_e             state_q, state_d;
    logic [CODE_W-1:0]  shift_q, shift_d;
    logic [BitW-1:0]    bit_q, bit_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [LockW-1:0]   lock_q, lock_d;
    logic [FailW-1:0]   fcnt_q, fcnt_d;
    logic               x_q, x_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ok_q, ok_d;
    logic               fail_q, fail_d;
    logic               lockout_q, lockout_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        wait_d  = wait_q;
        lock_d  = lock_q;
        fcnt_d  = fcnt_q;
        x_d     = 1'b0;
        done_d  = 1'b0;
        ok_d    = ok_q;
        fail_d  = fail_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // First bit goes out in the cycle right after acceptance.
                    x_d     = code[CODE_W-1];
                    shift_d = code << 1;
                    bit_d   = '0;
                    ok_d    = 1'b0;
                    fail_d  = 1'b0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (bit_q == BitLast) begin
                    wait_d  = '0;
                    state_d = StWaitResp;
                end else begin
                    x_d     = shift_q[CODE_W-1];
                    shift_d = shift_q << 1;
                    bit_d   = bit_q + 1'b1;
                end
            end
            StWaitResp: begin
                if (led_verde) begin
                    done_d  = 1'b1;
                    ok_d    = 1'b1;
                    fail_d  = 1'b0;
                    fcnt_d  = '0;
                    state_d = StIdle;
                end else if (led_vermelho || (wait_q == WaitLast)) begin
                    done_d = 1'b1;
                    ok_d   = 1'b0;
                    fail_d = 1'b1;
                    if (fcnt_q >= FailPrev) begin
                        fcnt_d  = FailMax;
                        lock_d  = '0;
                        state_d = StLockout;
                    end else begin
                        fcnt_d  = fcnt_q + 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StLockout: begin
                if (lock_q == LockLast) begin
                    fcnt_d  = '0;
                    lock_d  = '0;
                    state_d = StIdle;
                end else begin
                    lock_d = lock_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d    = (state_d != StIdle);
        lockout_d = (state_d == StLockout);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_q     <= '0;
            wait_q    <= '0;
            lock_q    <= '0;
            fcnt_q    <= '0;
            x_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            fail_q    <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            wait_q    <= wait_d;
            lock_q    <= lock_d;
            fcnt_q    <= fcnt_d;
            x_q       <= x_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ok_q      <= ok_d;
            fail_q    <= fail_d;
            lockout_q <= lockout_d;
        end
    end

    assign x       = x_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ok      = ok_q;
    assign fail    = fail_q;
    assign lockout = lockout_q;

endmodule

// File: tb/tb_transmissor_senha.sv
// Self-checking bench for transmissor_senha: table of attempts with expected results,
// plus hand sequences for lockout timing and mid-send reset.
module tb_transmissor_senha;

    localparam int CW = 6;
    localparam int RW = 4;
    localparam int LC = 16;

    logic          clock = 1'b0;
    logic          reset, start, led_verde, led_vermelho;
    logic [CW-1:0] code;
    logic          x, busy, done, ok, fail, lockout;

    int checks   = 0;
    int failures = 0;

    transmissor_senha #(
        .CODE_W     (CW),
        .RESP_WAIT  (RW),
        .MAX_FAIL   (3),
        .LOCK_CYCLES(LC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .code        (code),
        .led_verde   (led_verde),
        .led_vermelho(led_vermelho),
        .x           (x),
        .busy        (busy),
        .done        (done),
        .ok          (ok),
        .fail        (fail),
        .lockout     (lockout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [CW-1:0] code;
        int            led_at;   // wait cycle where LEDs are driven, -1 for none
        logic          verde;
        logic          verm;
        logic          noise;    // start/vermelho held high outside the response window
        logic          exp_ok;
        logic          exp_fail;
        logic          exp_lock;
    } vec_t;

    typedef struct {
        logic ok;
        logic fail;
        logic lock;
        int   wait_idx;
    } res_t;

    vec_t vecs[14];
    res_t res_q[$];
    logic exp_x_q[$];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_attempt(input vec_t v);
        res_t r;
        int   w;
        bit   seen;
        code         = v.code;
        start        = 1'b1;
        r.ok         = v.exp_ok;
        r.fail       = v.exp_fail;
        r.lock       = v.exp_lock;
        r.wait_idx   = (v.led_at < 0) ? RW - 1 : v.led_at;
        res_q.push_back(r);
        for (int i = 0; i < CW; i++) exp_x_q.push_back(v.code[CW-1-i]);
        tick;
        start        = v.noise;
        led_vermelho = v.noise;
        for (int k = 0; k < CW; k++) begin
            check("busy_send", busy, 1);
            check("x_bit", x, exp_x_q.pop_front());
            tick;
        end
        led_vermelho = 1'b0;
        check("x_wait", x, 0);
        check("busy_wait", busy, 1);
        seen = 0;
        w    = 0;
        while (!seen && w < RW) begin
            if (w == v.led_at) begin
                led_verde    = v.verde;
                led_vermelho = v.verm;
            end
            tick;
            led_verde    = 1'b0;
            led_vermelho = 1'b0;
            if (done === 1'b1) seen = 1;
            else w++;
        end
        start = 1'b0;
        r = res_q.pop_front();
        check("done_seen", 32'(seen), 1);
        check("resolve_cycle", w, r.wait_idx);
        check("ok", ok, r.ok);
        check("fail", fail, r.fail);
        check("lockout", lockout, r.lock);
        check("busy_resolve", busy, r.lock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //          code       led verde verm noise ok fail lock
        vecs[0]  = '{6'b101100,  1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{6'b000111,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{6'b000111,  2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{6'b110010, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{6'b010101,  3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{6'b111111,  0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{6'b011011,  1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{6'b100001, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{6'b001100,  2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{6'b101010,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{6'b010011, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{6'b110110,  3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{6'b000001,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{6'b100000, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        reset        = 1'b1;
        start        = 1'b0;
        led_verde    = 1'b0;
        led_vermelho = 1'b0;
        code         = '0;
        tick;
        tick;
        check("rst_x", x, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ok", ok, 0);
        check("rst_fail", fail, 0);
        check("rst_lockout", lockout, 0);
        reset = 1'b0;
        tick;

        for (int i = 0; i < 14; i++) begin
            run_attempt(vecs[i]);
            if (vecs[i].exp_lock) begin
                n     = 0;
                start = 1'b1;
                while (lockout === 1'b1 && n < 40) begin
                    check("lock_busy", busy, 1);
                    check("lock_x", x, 0);
                    n++;
                    tick;
                end
                start = 1'b0;
                check("lockout_len", n, LC);
                check("busy_after_lock", busy, 0);
                check("fail_held_lock", fail, 1);
            end else begin
                tick;
                check("done_pulse", done, 0);
                check("busy_idle", busy, 0);
                check("ok_held", ok, vecs[i].exp_ok);
                check("fail_held", fail, vecs[i].exp_fail);
            end
        end

        // Two failures are pending; a reset mid-send must clear the counter.
        code  = 6'b101100;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        check("third_bit", x, 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("abort_x", x, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ok", ok, 0);
        check("abort_fail", fail, 0);
        check("abort_lockout", lockout, 0);
        tick;
        check("abort_stays_idle", busy, 0);

        run_attempt('{6'b101100, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        tick;
        run_attempt('{6'b101100, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tick;
        check("final_done", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
